// File: rtl/mac_pkg.sv
// Shared binary32 format constants and the default accumulator width for the
// MAC normalize/round block.
package mac_pkg;
  localparam int unsigned EXP_W     = 8;
  localparam int unsigned FRAC_W    = 23;
  localparam int unsigned BIAS      = 127;
  localparam int unsigned EXP_MAX   = 255;
  localparam int unsigned SIG_W     = FRAC_W + 1;
  localparam int unsigned X_LEN_DEF = 74;
endpackage

// File: rtl/mac_round_rne.sv
// Round-to-nearest-even increment of a 24-bit significand (hidden one included).
module mac_round_rne
  import mac_pkg::*;
(
  input  logic [SIG_W-1:0] sig,
  input  logic             guard,
  input  logic             sticky,
  output logic [SIG_W-1:0] sig_rnd,
  output logic             carry
);
  logic           inc;
  logic [SIG_W:0] sum;

  always_comb begin
    inc     = guard & (sticky | sig[0]);
    sum     = {1'b0, sig} + {{SIG_W{1'b0}}, inc};
    sig_rnd = sum[SIG_W-1:0];
    carry   = sum[SIG_W];
  end
endmodule

// File: rtl/mac_normalize_round.sv
// Two-stage normalize (shift) and RNE round/pack of a MAC accumulator to binary32.
// Optional MAC_NORM_FLAGS_EN adds flags_o = {overflow, underflow, inexact}.
module mac_normalize_round
  import mac_pkg::*;
#(
  parameter int unsigned X_LEN          = X_LEN_DEF,
  parameter int unsigned PARM_SHIFTZERO = $clog2(X_LEN)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [X_LEN-1:0]          mant_i,
  input  logic [9:0]                exp_i,
  input  logic                      sign_i,
  input  logic [PARM_SHIFTZERO-1:0] shift_num_i,
  input  logic                      allzero_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [31:0]               result_o
`ifdef MAC_NORM_FLAGS_EN
  ,
  output logic [2:0]                flags_o
`endif
);
  logic               s1_valid, s2_valid, adv, in_fire;
  logic [X_LEN-1:0]   s1_norm;
  logic signed [10:0] s1_e;
  logic               s1_sign, s1_zero;

  assign adv         = !s2_valid | out_ready_i;
  assign in_ready_o  = !s1_valid | adv;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_valid_o = s2_valid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
    end else if (adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      s1_norm <= mant_i << shift_num_i;
      s1_e    <= {exp_i[9], exp_i} - 11'(shift_num_i);
      s1_sign <= sign_i;
      s1_zero <= allzero_i;
    end
  end

  logic [SIG_W-1:0]   sig_rnd;
  logic               guard, sticky, carry;
  logic [FRAC_W-1:0]  frac;
  logic signed [11:0] e_fin;
  logic               ovf, unf;
  logic [31:0]        packed_res;

  assign guard  = s1_norm[48];
  assign sticky = |s1_norm[47:0];

  mac_round_rne u_round (
    .sig     (s1_norm[72:49]),
    .guard   (guard),
    .sticky  (sticky),
    .sig_rnd (sig_rnd),
    .carry   (carry)
  );

  always_comb begin
    frac  = carry ? '0 : sig_rnd[FRAC_W-1:0];
    e_fin = {s1_e[10], s1_e} + 12'(carry);
    ovf   = e_fin >= $signed(12'(EXP_MAX));
    unf   = e_fin <= 12'sd0;
    if (s1_zero) begin
      packed_res = '0;
    end else if (ovf) begin
      packed_res = {s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (unf) begin
      packed_res = {s1_sign, 31'b0};
    end else begin
      packed_res = {s1_sign, e_fin[EXP_W-1:0], frac};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      result_o <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result_o <= packed_res;
      end
    end
  end

`ifdef MAC_NORM_FLAGS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flags_o <= '0;
    end else if (adv && s1_valid) begin
      flags_o <= s1_zero ? 3'b000 : {ovf, unf, guard | sticky};
    end
  end
`endif

  // Hidden bit of the rounded significand and headroom above bit 72 carry no result information.
  logic rnd_unused;
  assign rnd_unused = sig_rnd[SIG_W-1];

  if (X_LEN > 73) begin : g_hi
    logic norm_hi_unused;
    assign norm_hi_unused = |s1_norm[X_LEN-1:73];
  end
endmodule

// File: tb/tb_mac_normalize_round.sv
// Scoreboard bench for mac_normalize_round: directed corner cases plus random traffic
// against an arithmetic reference model, with random and forced backpressure.
module tb_mac_normalize_round;
  import mac_pkg::*;

  localparam int unsigned XL = 74;
  localparam int unsigned SW = 7;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [XL-1:0] mant_i = '0;
  logic [9:0]    exp_i = '0;
  logic          sign_i = 1'b0;
  logic [SW-1:0] shift_num_i = '0;
  logic          allzero_i = 1'b0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [31:0]   result_o;
`ifdef MAC_NORM_FLAGS_EN
  logic [2:0]    flags_o;
`endif

  mac_normalize_round #(.X_LEN(XL), .PARM_SHIFTZERO(SW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .mant_i      (mant_i),
    .exp_i       (exp_i),
    .sign_i      (sign_i),
    .shift_num_i (shift_num_i),
    .allzero_i   (allzero_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o)
`ifdef MAC_NORM_FLAGS_EN
    ,
    .flags_o     (flags_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flags;
    int unsigned issue;
    bit          chk_lat;
  } exp_t;

  exp_t        sbq[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned rdy_mode = 0;   // 0: always ready, 1: stalled, 2: random

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready_i = 1'b1;
      1:       out_ready_i = 1'b0;
      default: out_ready_i = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Reference: value = 1.f * 2^(e-BIAS); round the 49 bits below the 24-bit significand to nearest-even.
  function automatic logic [34:0] ref_fp(input logic [XL-1:0] m, input int e, input int s,
                                         input bit sg, input bit z);
    logic [XL-1:0]   n;
    longint unsigned top;
    longint unsigned rem;
    longint unsigned half;
    int              ex;
    logic [2:0]      fl;
    if (z) return '0;
    n    = m << s;
    top  = longint'(n[72:49]);
    rem  = longint'(n[48:0]);
    half = 64'd1 << 48;
    ex   = e - s;
    fl   = {2'b00, rem != 0};
    if (rem > half || (rem == half && top[0])) top++;
    if (top == (64'd1 << 24)) begin
      top = top >> 1;
      ex++;
    end
    if (ex >= int'(EXP_MAX)) return {fl | 3'b100, sg, 8'hff, 23'h0};
    if (ex <= 0)             return {fl | 3'b010, sg, 31'h0};
    return {fl, sg, 8'(ex), top[22:0]};
  endfunction

  task automatic push_exp(input logic [34:0] k, input bit lat);
    exp_t x;
    x.res     = k[31:0];
    x.flags   = k[34:32];
    x.issue   = cyc;
    x.chk_lat = lat;
    sbq.push_back(x);
  endtask

  task automatic present(input logic [XL-1:0] m, input int e, input int s, input bit sg, input bit z);
    mant_i      = m;
    exp_i       = 10'(e);
    shift_num_i = SW'(s);
    sign_i      = sg;
    allzero_i   = z;
    in_valid_i  = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the edge that took the operand.
  task automatic send(input logic [XL-1:0] m, input int e, input int s, input bit sg, input bit z,
                      input bit lat, input bit use_k, input logic [34:0] k);
    int unsigned n;
    n = 0;
    present(m, e, s, sg, z);
    forever begin
      @(negedge clk);
      if (in_ready_o) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout in_ready=%0b required 1", in_ready_o);
        in_valid_i = 1'b0;
        return;
      end
    end
    push_exp(use_k ? k : ref_fp(m, e, s, sg, z), lat);
    @(posedge clk);
    #2;
    in_valid_i = 1'b0;
  endtask

  task automatic gen(output logic [XL-1:0] m, output int e, output int s, output bit sg, output bit z);
    m = {2'b01, 32'($urandom), 32'($urandom), 8'($urandom)};
    case ($urandom_range(0, 3))
      0: m = m & ~((XL'(1) << $urandom_range(0, 50)) - XL'(1));
      1: begin
        m[47:0] = '0;
        m[48]   = 1'b1;
      end
      default: ;
    endcase
    s  = $urandom_range(0, 40);
    m  = m >> s;
    e  = s + $urandom_range(0, 270) - 8;
    sg = $urandom_range(0, 1);
    z  = ($urandom_range(0, 15) == 0);
    if (z) m = '0;
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks hold-under-stall.
  bit          hold_prev = 0;
  logic [31:0] prev_res;
  always @(negedge clk) begin
    exp_t x;
    if (rst_i) begin
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        checks++;
        if (!out_valid_o || result_o !== prev_res) begin
          errors++;
          $display("FAIL hold valid=%0b result=%08h required valid=1 result=%08h",
                   out_valid_o, result_o, prev_res);
        end
      end
      if (out_valid_o && out_ready_i) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output result=%08h required no output", result_o);
        end else begin
          x = sbq.pop_front();
          if (result_o !== x.res) begin
            errors++;
            $display("FAIL result got=%08h required=%08h", result_o, x.res);
          end
          if (x.chk_lat) begin
            checks++;
            if (cyc - x.issue != 2) begin
              errors++;
              $display("FAIL latency got=%0d required=2", cyc - x.issue);
            end
          end
`ifdef MAC_NORM_FLAGS_EN
          checks++;
          if (flags_o !== x.flags) begin
            errors++;
            $display("FAIL flags got=%03b required=%03b", flags_o, x.flags);
          end
`endif
        end
      end
      hold_prev = out_valid_o && !out_ready_i;
      prev_res  = result_o;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, want);
    end
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required 0", sbq.size());
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [XL-1:0] one72, m;
    logic [XL-1:0] ones;
    int            e, s;
    bit            sg, z;
    int unsigned   acc;

    one72 = XL'(1) << 72;
    ones  = {1'b0, {25{1'b1}}, {48{1'b0}}};

    repeat (3) @(posedge clk);
    #2;
    rst_i = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid_o), 32'd0);
    check("reset_result", result_o, 32'h0);
    check("ready_after_reset", 32'(in_ready_o), 32'd1);
    @(posedge clk);
    #2;

    send(one72, int'(BIAS), 0, 0, 0, 1, 1, {3'b000, 32'h3F800000});
    send(XL'(1) << 40, 159, 32, 0, 0, 1, 1, {3'b000, 32'h3F800000});
    send(XL'(1) << 40, 159, 32, 1, 0, 1, 1, {3'b000, 32'hBF800000});
    send(one72 | (XL'(1) << 48), 127, 0, 0, 0, 1, 1, {3'b001, 32'h3F800000});
    send(one72 | (XL'(1) << 49) | (XL'(1) << 48), 127, 0, 0, 0, 1, 1, {3'b001, 32'h3F800002});
    send(one72 | (XL'(1) << 48) | XL'(1), 127, 0, 0, 0, 1, 1, {3'b001, 32'h3F800001});
    send(ones, 254, 0, 0, 0, 1, 1, {3'b101, 32'h7F800000});
    send(one72, 0, 0, 0, 0, 1, 1, {3'b010, 32'h00000000});
    send(one72, -5, 0, 1, 0, 1, 1, {3'b010, 32'h80000000});
    send(one72, 1, 0, 0, 0, 1, 1, {3'b000, 32'h00800000});
    send(one72, 255, 0, 1, 0, 1, 1, {3'b100, 32'hFF800000});
    send('0, 100, 0, 1, 1, 1, 1, {3'b000, 32'h00000000});
    drain();

    // Stalled output: only two operands fit before the input side backs up.
    rdy_mode = 1;
    @(posedge clk);
    #2;
    acc = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (acc < 4) begin
        gen(m, e, s, sg, z);
        present(m, e, s, sg, z);
      end else begin
        in_valid_i = 1'b0;
      end
      @(negedge clk);
      if (in_valid_i && in_ready_o) begin
        push_exp(ref_fp(m, e, s, sg, z), 0);
        acc++;
      end
      @(posedge clk);
      #2;
    end
    check("bp_accepted", acc, 32'd2);
    check("bp_in_ready", 32'(in_ready_o), 32'd0);
    rdy_mode = 0;
    in_valid_i = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      gen(m, e, s, sg, z);
      send(m, e, s, sg, z, 0, 0, '0);
    end
    drain();

    // Reset with both stages occupied discards them.
    rdy_mode = 1;
    @(posedge clk);
    #2;
    for (int unsigned i = 0; i < 2; i++) begin
      gen(m, e, s, sg, z);
      send(m, e, s, sg, z, 0, 0, '0);
    end
    rst_i = 1'b1;
    @(posedge clk);
    #2;
    rst_i = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("rst_flush_valid", 32'(out_valid_o), 32'd0);
    check("rst_flush_result", result_o, 32'h0);
    check("rst_flush_ready", 32'(in_ready_o), 32'd1);
    rdy_mode = 0;
    repeat (6) @(posedge clk);
    #2;

    rdy_mode = 2;
    for (int unsigned i = 0; i < 200; i++) begin
      gen(m, e, s, sg, z);
      send(m, e, s, sg, z, 0, 0, '0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #2;
    end
    rdy_mode = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
